wb_dest_pipe: RTL and testbench

Parametrised successor to the combinational write-register select. Picks the write-back destination register from rt, rd or a fixed link register, or none, under a 2-bit mode. It carries that destination and its write-enable through a STAGES-deep register pipeline (ID→EX→MEM→WB), with stall and flush. It also reports pending-write hazards against two source-register queries, for the hazard/forwarding unit.

---
 rtl/wb_dest_pipe.sv | 97 +++++++++
 tb/tb_wb_dest_pipe.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_dest_pipe.sv
// Write-back destination select with a STAGES-deep {valid, dst} pipeline,
// stall/flush control and pending-write hazard reporting for source queries.
module wb_dest_pipe #(
  parameter int REG_W    = 5,
  parameter int STAGES   = 3,
  parameter int LINK_REG = 31
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   RegDst,
  input  logic                         regWrite_in,
  input  logic [REG_W-1:0]             rt,
  input  logic [REG_W-1:0]             rd,
  input  logic                         stall,
  input  logic                         flush,
  input  logic [REG_W-1:0]             rs_q,
  input  logic [REG_W-1:0]             rt_q,
  output logic [REG_W-1:0]             writeReg,
  output logic                         regWrite,
  output logic                         hazard_rs,
  output logic                         hazard_rt,
  output logic [$clog2(STAGES+1)-1:0]  pend_count
);

  localparam int CNT_W = $clog2(STAGES+1);
  localparam logic [REG_W-1:0] LINK_DST = REG_W'(LINK_REG);
  localparam logic [REG_W-1:0] ZERO_DST = {REG_W{1'b0}};

  logic [REG_W-1:0] selDst_s;
  logic             selV_s;
  logic [STAGES-1:0] stageV_r;
  logic [REG_W-1:0]  stageDst_r [STAGES];
  logic              hazRs_s;
  logic              hazRt_s;
  logic [CNT_W-1:0]  pendCnt_s;

  // Destination mux; writes aimed at $0 never become valid.
  always_comb begin
    selDst_s = ZERO_DST;
    case (RegDst)
      2'd0:    selDst_s = rt;
      2'd1:    selDst_s = rd;
      2'd2:    selDst_s = LINK_DST;
      2'd3:    selDst_s = ZERO_DST;
      default: selDst_s = ZERO_DST;
    endcase
    selV_s = regWrite_in & (RegDst != 2'd3) & (selDst_s != ZERO_DST);
  end

  // Stage registers: flush beats stall; a stalled cycle drops the select inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stageV_r <= {STAGES{1'b0}};
      for (int i = 0; i < STAGES; i++) stageDst_r[i] <= ZERO_DST;
    end else if (flush) begin
      stageV_r <= {STAGES{1'b0}};
      for (int i = 0; i < STAGES; i++) stageDst_r[i] <= ZERO_DST;
    end else if (stall) begin
      stageV_r <= stageV_r;
      for (int i = 0; i < STAGES; i++) stageDst_r[i] <= stageDst_r[i];
    end else begin
      stageV_r[0]   <= selV_s;
      stageDst_r[0] <= selDst_s;
      for (int i = 1; i < STAGES; i++) begin
        stageV_r[i]   <= stageV_r[i-1];
        stageDst_r[i] <= stageDst_r[i-1];
      end
    end
  end

  // Hazards and occupancy look at every stage, including the one writing back.
  always_comb begin
    hazRs_s   = 1'b0;
    hazRt_s   = 1'b0;
    pendCnt_s = {CNT_W{1'b0}};
    for (int i = 0; i < STAGES; i++) begin
      if (stageV_r[i] && (stageDst_r[i] == rs_q) && (rs_q != ZERO_DST)) begin
        hazRs_s = 1'b1;
      end else begin
        hazRs_s = hazRs_s;
      end
      if (stageV_r[i] && (stageDst_r[i] == rt_q) && (rt_q != ZERO_DST)) begin
        hazRt_s = 1'b1;
      end else begin
        hazRt_s = hazRt_s;
      end
      pendCnt_s = pendCnt_s + CNT_W'(stageV_r[i]);
    end
  end

  assign writeReg   = stageDst_r[STAGES-1];
  assign regWrite   = stageV_r[STAGES-1];
  assign hazard_rs  = hazRs_s;
  assign hazard_rt  = hazRt_s;
  assign pend_count = pendCnt_s;

endmodule

// File: tb/tb_wb_dest_pipe.sv
// Directed bench for wb_dest_pipe at default parameters (STAGES=3, LINK_REG=31).
module tb_wb_dest_pipe;

  logic       clk;
  logic       rst_n;
  logic [1:0] RegDst;
  logic       regWrite_in;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       stall;
  logic       flush;
  logic [4:0] rs_q;
  logic [4:0] rt_q;
  logic [4:0] writeReg;
  logic       regWrite;
  logic       hazard_rs;
  logic       hazard_rt;
  logic [1:0] pend_count;

  int passed;
  int total;

  wb_dest_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RegDst     (RegDst),
    .regWrite_in(regWrite_in),
    .rt         (rt),
    .rd         (rd),
    .stall      (stall),
    .flush      (flush),
    .rs_q       (rs_q),
    .rt_q       (rt_q),
    .writeReg   (writeReg),
    .regWrite   (regWrite),
    .hazard_rs  (hazard_rs),
    .hazard_rt  (hazard_rt),
    .pend_count (pend_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] mode, input logic wr, input logic [4:0] rtv, input logic [4:0] rdv);
    RegDst      = mode;
    regWrite_in = wr;
    rt          = rtv;
    rd          = rdv;
  endtask

  task automatic chkOut(input string tag, input logic [4:0] wReg, input logic wEn,
                        input logic hRs, input logic hRt, input logic [1:0] cnt);
    chk({tag, ".writeReg"}, 32'(writeReg), 32'(wReg));
    chk({tag, ".regWrite"}, 32'(regWrite), 32'(wEn));
    chk({tag, ".hazard_rs"}, 32'(hazard_rs), 32'(hRs));
    chk({tag, ".hazard_rt"}, 32'(hazard_rt), 32'(hRt));
    chk({tag, ".pend_count"}, 32'(pend_count), 32'(cnt));
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    stall  = 1'b0;
    flush  = 1'b0;
    rs_q   = 5'd0;
    rt_q   = 5'd0;
    drive(2'd3, 1'b0, 5'd0, 5'd0);
    tick();
    tick();
    chkOut("reset", 5'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    rst_n = 1'b1;
    tick();
    chkOut("idle", 5'd0, 1'b0, 1'b0, 1'b0, 2'd0);

    // rd mode, one-cycle write of 9
    drive(2'd1, 1'b1, 5'd4, 5'd9);
    tick();
    drive(2'd3, 1'b0, 5'd0, 5'd0);
    chk("rd.e1.cnt", 32'(pend_count), 32'd1);
    chk("rd.e1.we", 32'(regWrite), 32'd0);
    tick();
    chk("rd.e2.cnt", 32'(pend_count), 32'd1);
    chk("rd.e2.we", 32'(regWrite), 32'd0);
    tick();
    chkOut("rd.e3", 5'd9, 1'b1, 1'b0, 1'b0, 2'd1);
    tick();
    chk("rd.e4.we", 32'(regWrite), 32'd0);
    chk("rd.e4.cnt", 32'(pend_count), 32'd0);

    // link mode
    drive(2'd2, 1'b1, 5'd3, 5'd3);
    tick();
    drive(2'd3, 1'b0, 5'd0, 5'd0);
    tick();
    tick();
    chk("link.wreg", 32'(writeReg), 32'd31);
    chk("link.we", 32'(regWrite), 32'd1);
    tick();

    // write to $0 is never valid
    drive(2'd0, 1'b1, 5'd0, 5'd6);
    tick();
    chk("zero.e1.cnt", 32'(pend_count), 32'd0);
    drive(2'd3, 1'b0, 5'd0, 5'd0);
    tick();
    tick();
    chk("zero.e3.we", 32'(regWrite), 32'd0);
    chk("zero.e3.cnt", 32'(pend_count), 32'd0);

    // hazard tracking for rt=5 across its flight
    rs_q = 5'd5;
    rt_q = 5'd6;
    drive(2'd0, 1'b1, 5'd5, 5'd0);
    #1;
    chk("haz.pre.rs", 32'(hazard_rs), 32'd0);
    tick();
    drive(2'd3, 1'b0, 5'd0, 5'd0);
    chkOut("haz.e1", 5'd0, 1'b0, 1'b1, 1'b0, 2'd1);
    tick();
    chk("haz.e2.rs", 32'(hazard_rs), 32'd1);
    chk("haz.e2.rt", 32'(hazard_rt), 32'd0);
    tick();
    chkOut("haz.e3", 5'd5, 1'b1, 1'b1, 1'b0, 2'd1);
    rs_q = 5'd0;
    rt_q = 5'd5;
    #1;
    chk("haz.rs0", 32'(hazard_rs), 32'd0);
    chk("haz.rtq5", 32'(hazard_rt), 32'd1);
    rs_q = 5'd5;
    rt_q = 5'd6;
    tick();
    chk("haz.e4.rs", 32'(hazard_rs), 32'd0);

    // load 7, 8, 10 then stall 4 cycles with new inputs offered
    drive(2'd0, 1'b1, 5'd7, 5'd0);
    tick();
    drive(2'd1, 1'b1, 5'd0, 5'd8);
    tick();
    drive(2'd0, 1'b1, 5'd10, 5'd0);
    tick();
    chkOut("load3", 5'd7, 1'b1, 1'b0, 1'b0, 2'd3);
    stall = 1'b1;
    drive(2'd1, 1'b1, 5'd0, 5'd20);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall.wreg", 32'(writeReg), 32'd7);
      chk("stall.we", 32'(regWrite), 32'd1);
      chk("stall.cnt", 32'(pend_count), 32'd3);
    end
    stall = 1'b0;
    drive(2'd3, 1'b0, 5'd0, 5'd0);
    tick();
    chkOut("rel.e1", 5'd8, 1'b1, 1'b0, 1'b0, 2'd2);
    tick();
    chkOut("rel.e2", 5'd10, 1'b1, 1'b0, 1'b0, 2'd1);
    tick();
    chk("rel.e3.we", 32'(regWrite), 32'd0);
    chk("rel.e3.cnt", 32'(pend_count), 32'd0);

    // flush overrides stall
    drive(2'd0, 1'b1, 5'd11, 5'd0);
    tick();
    drive(2'd0, 1'b1, 5'd12, 5'd0);
    tick();
    drive(2'd3, 1'b0, 5'd0, 5'd0);
    rs_q = 5'd11;
    rt_q = 5'd12;
    #1;
    chkOut("preflush", 5'd0, 1'b0, 1'b1, 1'b1, 2'd2);
    stall = 1'b1;
    flush = 1'b1;
    tick();
    stall = 1'b0;
    flush = 1'b0;
    chkOut("flush", 5'd0, 1'b0, 1'b0, 1'b0, 2'd0);

    // asynchronous reset mid-stream
    drive(2'd0, 1'b1, 5'd13, 5'd0);
    tick();
    drive(2'd0, 1'b1, 5'd14, 5'd0);
    tick();
    drive(2'd0, 1'b1, 5'd15, 5'd0);
    tick();
    drive(2'd3, 1'b0, 5'd0, 5'd0);
    rs_q = 5'd13;
    rt_q = 5'd15;
    #1;
    chkOut("prerst", 5'd13, 1'b1, 1'b1, 1'b1, 2'd3);
    rst_n = 1'b0;
    #1;
    chkOut("asyncrst", 5'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    rst_n = 1'b1;
    drive(2'd1, 1'b1, 5'd0, 5'd17);
    tick();
    drive(2'd3, 1'b0, 5'd0, 5'd0);
    chk("resume.cnt", 32'(pend_count), 32'd1);
    tick();
    tick();
    chk("resume.wreg", 32'(writeReg), 32'd17);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
